// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the rr_arbiter4 round-robin arbiter.
//   - arb_state_e : two-state controller encoding (IDLE / GRANT)
//   - ARB_NREQ    : number of requesters
//   - ARB_IDW     : width of a requester index
//   - ARB_LAST_RST: reset value of the rotating pointer, so requester 0
//                   has first priority after reset
//   - rr_pick     : round-robin winner search starting after the pointer
package arb_pkg;

  localparam int ARB_NREQ = 4;
  localparam int ARB_IDW  = 2;

  localparam logic [ARB_IDW-1:0] ARB_LAST_RST = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request bit scanning last+1, last+2, ... last+ARB_NREQ (mod
  // ARB_NREQ). The loop runs from the farthest offset down to the nearest so
  // the nearest set bit overwrites the others. Returns 'last' when req is 0.
  function automatic logic [ARB_IDW-1:0] rr_pick(
    input logic [ARB_NREQ-1:0] req,
    input logic [ARB_IDW-1:0]  last
  );
    logic [ARB_IDW-1:0] pick;
    logic [ARB_IDW-1:0] idx;
    pick = last;
    for (int k = ARB_NREQ; k >= 1; k--) begin
      idx = last + ARB_IDW'(k);
      if (req[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between the requesting agents and the
// arbiter.
//   En      : arbitration enable (agents -> arbiter)
//   req     : request lines, one per requester (agents -> arbiter)
//   gnt     : one-hot grant or zero (arbiter -> agents)
//   gnt_id  : binary index of current / last owner (arbiter -> resource)
//   busy    : a grant is active (arbiter -> agents)
//   timeout : one-cycle pulse when a grant is forcibly revoked
// Modports: master = agent side, slave = arbiter side.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic                En;
  logic [ARB_NREQ-1:0] req;
  logic [ARB_NREQ-1:0] gnt;
  logic [ARB_IDW-1:0]  gnt_id;
  logic                busy;
  logic                timeout;

  modport master (
    output En,
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  En,
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

endinterface

// File: rtl/onehot_dec2to4.sv
// onehot_dec2to4: combinational 2-to-4 one-hot decoder.
//   Din[1:0] : binary index
//   En       : decode enable; low forces Do to 4'b0000
//   Do[3:0]  : one-hot output
module onehot_dec2to4 (
  input  logic [1:0] Din,
  input  logic       En,
  output logic [3:0] Do
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign Do[gi] = En && (Din == 2'(gi));
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with registered one-hot grant.
//   clk  : clock, all registers update on the rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_arbiter4_if.slave (En, req in; gnt, gnt_id, busy, timeout out)
// Parameter MAX_HOLD (2..255): grant cycles allowed per owner before the
// grant is revoked; only used when the macro ARB_TIMEOUT_EN is defined.
// Without ARB_TIMEOUT_EN there is no hold counter and timeout is tied 0.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave bus
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be in 2..255");
  end

  arb_state_e          state_reg, state_next;
  logic [ARB_IDW-1:0]  last_id_reg, last_id_next;
  logic [ARB_IDW-1:0]  gnt_id_reg, gnt_id_next;
  logic                busy_reg, busy_next;
  logic [ARB_NREQ-1:0] gnt_reg;
  logic [ARB_NREQ-1:0] gnt_dec;

`ifdef ARB_TIMEOUT_EN
  // Counter holds (grant cycles elapsed - 1), so expiry is seen at the edge
  // that ends the MAX_HOLD-th grant cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic       timeout_reg, timeout_next;
`endif

  always_comb begin
    state_next   = state_reg;
    last_id_next = last_id_reg;
    gnt_id_next  = gnt_id_reg;
    busy_next    = busy_reg;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.En && (|bus.req)) begin
          state_next   = GRANT;
          gnt_id_next  = rr_pick(bus.req, last_id_reg);
          last_id_next = gnt_id_next;
          busy_next    = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_next = 8'd0;
`endif
        end
      end
      GRANT: begin
        // Release wins over expiry, so a coincident drop is a normal release.
        if (!bus.req[gnt_id_reg]) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_reg == HOLD_LAST) begin
          state_next   = IDLE;
          busy_next    = 1'b0;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Decoding the next-state index lets gnt register in the same cycle as
  // gnt_id/busy, so gnt always equals decode(gnt_id) gated by busy.
  onehot_dec2to4 u_dec (
    .Din (gnt_id_next),
    .En  (busy_next),
    .Do  (gnt_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_id_reg <= ARB_LAST_RST;
      gnt_id_reg  <= '0;
      busy_reg    <= 1'b0;
      gnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      last_id_reg <= last_id_next;
      gnt_id_reg  <= gnt_id_next;
      busy_reg    <= busy_next;
      gnt_reg     <= gnt_dec;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.timeout = timeout_reg;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt    = gnt_reg;
  assign bus.gnt_id = gnt_id_reg;
  assign bus.busy   = busy_reg;

endmodule
